// File: rtl/wb_regfile.sv
// Writeback stage + register file: MEM captured in 1 cycle, committed the next; stall holds the slot and blocks all updates.
// Optional macro WB_BYPASS_EN forwards the committing WB result to the combinational read ports.
module wb_regfile #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int CRW     = 2,
  parameter int R0_ZERO = 1,
  localparam int RA     = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  mem_bubble,
  input  logic [XLEN-1:0]       mem_pc,
  input  logic [XLEN-1:0]       mem_res,
  input  logic [RA-1:0]         mem_rd,
  input  logic                  mem_w_rd,
  input  logic                  mem_w_cr,
  input  logic [CRW-1:0]        mem_cmp_res,
  output logic [XLEN-1:0]       wb_pc,
  output logic [XLEN-1:0]       wb_res,
  output logic [RA-1:0]         wb_rd,
  output logic                  wb_w_rd,
  output logic                  wb_bubble,
  input  logic [NRD*RA-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [CRW-1:0]        cmp_reg,
  output logic [63:0]           instret
);

  logic [XLEN-1:0] regs [NREGS];
  logic            stg_w_rd;
  logic            r0_hit;

  assign r0_hit  = (R0_ZERO != 0) && (wb_rd == '0);
  assign wb_w_rd = stg_w_rd && !wb_bubble && !stall && !r0_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_pc     <= '0;
      wb_res    <= '0;
      wb_rd     <= '0;
      stg_w_rd  <= 1'b0;
      wb_bubble <= 1'b1;
      cmp_reg   <= '0;
      instret   <= '0;
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      // The held slot commits on the same edge that loads its successor.
      if (wb_w_rd) regs[wb_rd] <= wb_res;
      if (!wb_bubble && !stall) instret <= instret + 64'd1;
      if (mem_w_cr && !mem_bubble && !stall) cmp_reg <= mem_cmp_res;
      if (!stall) begin
        wb_pc     <= mem_pc;
        wb_res    <= mem_res;
        wb_rd     <= mem_rd;
        stg_w_rd  <= mem_w_rd;
        wb_bubble <= mem_bubble;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [RA-1:0]   addr;
    logic [XLEN-1:0] data;
    assign addr = rd_addr[i*RA +: RA];
    always_comb begin
      data = regs[addr];
`ifdef WB_BYPASS_EN
      if (wb_w_rd && addr == wb_rd) data = wb_res;
`endif
      if ((R0_ZERO != 0) && addr == '0) data = '0;
    end
    assign rd_data[i*XLEN +: XLEN] = data;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expected values, a negedge monitor pops and compares them.
module tb_wb_regfile;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int CRW = 2;
  localparam int RA = 5;

  logic                clk = 1'b0;
  logic                rst, stall, mem_bubble, mem_w_rd, mem_w_cr;
  logic [XLEN-1:0]     mem_pc, mem_res;
  logic [RA-1:0]       mem_rd;
  logic [CRW-1:0]      mem_cmp_res;
  logic [XLEN-1:0]     wb_pc, wb_res;
  logic [RA-1:0]       wb_rd;
  logic                wb_w_rd, wb_bubble;
  logic [NRD*RA-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [CRW-1:0]      cmp_reg;
  logic [63:0]         instret;

  wb_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CRW(CRW), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .mem_bubble(mem_bubble), .mem_pc(mem_pc),
    .mem_res(mem_res), .mem_rd(mem_rd), .mem_w_rd(mem_w_rd), .mem_w_cr(mem_w_cr),
    .mem_cmp_res(mem_cmp_res), .wb_pc(wb_pc), .wb_res(wb_res), .wb_rd(wb_rd),
    .wb_w_rd(wb_w_rd), .wb_bubble(wb_bubble), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmp_reg(cmp_reg), .instret(instret));

  always #5 clk = ~clk;

  localparam int K_RD0 = 0, K_RD1 = 1, K_CMP = 2, K_INSTRET = 3, K_BUBBLE = 4, K_WREN = 5, K_WBRES = 6;

  typedef struct {
    int          kind;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = q.pop_front();
      case (e.kind)
        K_RD0:     act = {32'd0, rd_data[XLEN-1:0]};
        K_RD1:     act = {32'd0, rd_data[2*XLEN-1:XLEN]};
        K_CMP:     act = {62'd0, cmp_reg};
        K_INSTRET: act = instret;
        K_BUBBLE:  act = {63'd0, wb_bubble};
        K_WREN:    act = {63'd0, wb_w_rd};
        default:   act = {32'd0, wb_res};
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic expect_val(input int kind, input logic [63:0] v, input string n);
    exp_t e;
    e.kind = kind; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_bubble = 1'b1; mem_w_rd = 1'b0; mem_w_cr = 1'b0;
    mem_rd = '0; mem_res = '0; mem_cmp_res = '0; mem_pc = '0;
  endtask

  task automatic issue(input logic [RA-1:0] rd, input logic [XLEN-1:0] res, input logic [XLEN-1:0] pc);
    mem_bubble = 1'b0; mem_w_rd = 1'b1; mem_w_cr = 1'b0;
    mem_rd = rd; mem_res = res; mem_pc = pc;
  endtask

  task automatic raddr(input logic [RA-1:0] a0, input logic [RA-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    stall = 1'b0; raddr(5'd5, 5'd0);
    rst = 1'b1;
    issue(5'd5, 32'h55, 32'h100);
    tick(); tick();
    rst = 1'b0; idle();
    expect_val(K_BUBBLE, 64'd1, "reset_bubble");
    expect_val(K_INSTRET, 64'd0, "reset_instret");
    expect_val(K_CMP, 64'd0, "reset_cmp");
    expect_val(K_RD0, 64'd0, "reset_r5");
    expect_val(K_RD1, 64'd0, "reset_r0");
    tick();

    // basic commit
    issue(5'd5, 32'hDEADBEEF, 32'h104);
    tick(); idle();
    expect_val(K_WBRES, 64'hDEADBEEF, "basic_wb_res");
    expect_val(K_WREN, 64'd1, "basic_wb_w_rd");
    expect_val(K_INSTRET, 64'd0, "basic_instret_pre");
    tick();
    expect_val(K_RD0, 64'hDEADBEEF, "basic_r5");
    expect_val(K_INSTRET, 64'd1, "basic_instret");
    expect_val(K_BUBBLE, 64'd1, "basic_bubble_after");

    // write to r0
    issue(5'd0, 32'h1234, 32'h108);
    tick(); idle(); raddr(5'd0, 5'd5);
    expect_val(K_WREN, 64'd0, "r0_wb_w_rd");
    expect_val(K_RD0, 64'd0, "r0_read_wb");
    tick();
    expect_val(K_RD0, 64'd0, "r0_read_after");
    expect_val(K_INSTRET, 64'd2, "r0_instret");

    // stall hold for 3 cycles, with new MEM content that must be neither captured nor flag-written
    issue(5'd3, 32'd7, 32'h10C);
    tick();
    stall = 1'b1; issue(5'd4, 32'h99, 32'h110); mem_w_cr = 1'b1; mem_cmp_res = 2'b01;
    raddr(5'd3, 5'd4);
    for (int c = 0; c < 3; c++) begin
      expect_val(K_WBRES, 64'd7, "stall_wb_res");
      expect_val(K_WREN, 64'd0, "stall_wb_w_rd");
      expect_val(K_RD0, 64'd0, "stall_r3");
      expect_val(K_INSTRET, 64'd2, "stall_instret");
      expect_val(K_CMP, 64'd0, "stall_cmp");
      tick();
    end
    stall = 1'b0; idle();
    expect_val(K_WREN, 64'd1, "stall_release_wen");
`ifdef WB_BYPASS_EN
    expect_val(K_RD0, 64'd7, "stall_release_r3_bypass");
`else
    expect_val(K_RD0, 64'd0, "stall_release_r3_old");
`endif
    tick();
    expect_val(K_RD0, 64'd7, "stall_commit_r3");
    expect_val(K_INSTRET, 64'd3, "stall_commit_instret");
    expect_val(K_BUBBLE, 64'd1, "stall_commit_bubble");
    tick();
    expect_val(K_INSTRET, 64'd3, "stall_once_instret");
    expect_val(K_RD1, 64'd0, "stall_r4_untouched");

    // flags: bubble must not write, real slot does
    idle(); mem_w_cr = 1'b1; mem_cmp_res = 2'b10;
    tick(); idle();
    expect_val(K_CMP, 64'd0, "flag_bubble_cmp");
    mem_bubble = 1'b0; mem_w_cr = 1'b1; mem_cmp_res = 2'b10;
    tick(); idle();
    expect_val(K_CMP, 64'd2, "flag_write_cmp");
    tick();
    expect_val(K_INSTRET, 64'd4, "flag_instret");
    expect_val(K_CMP, 64'd2, "flag_hold_cmp");

    // bypass: r9 holds 0x11, then 0xA5 commits while port 1 reads r9
    issue(5'd9, 32'h11, 32'h120);
    tick(); idle(); tick();
    issue(5'd9, 32'hA5, 32'h124);
    tick(); idle(); raddr(5'd0, 5'd9);
    expect_val(K_WREN, 64'd1, "bypass_wen");
`ifdef WB_BYPASS_EN
    expect_val(K_RD1, 64'hA5, "bypass_r9_new");
`else
    expect_val(K_RD1, 64'h11, "bypass_r9_old");
`endif
    tick();
    expect_val(K_RD1, 64'hA5, "bypass_r9_after");

    // back-to-back writes to r6
    issue(5'd6, 32'd1, 32'h130);
    tick();
    issue(5'd6, 32'd2, 32'h134);
    tick(); idle(); tick();
    raddr(5'd6, 5'd9);
    expect_val(K_RD0, 64'd2, "b2b_r6_last");
    expect_val(K_INSTRET, 64'd8, "b2b_instret");

    // reset wins over stall, in-flight slot is discarded
    issue(5'd7, 32'h77, 32'h140);
    tick();
    rst = 1'b1; stall = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0; idle(); raddr(5'd6, 5'd7);
    expect_val(K_INSTRET, 64'd0, "rst2_instret");
    expect_val(K_BUBBLE, 64'd1, "rst2_bubble");
    expect_val(K_CMP, 64'd0, "rst2_cmp");
    expect_val(K_RD0, 64'd0, "rst2_r6");
    tick();
    expect_val(K_RD1, 64'd0, "rst2_r7_discarded");
    expect_val(K_INSTRET, 64'd0, "rst2_instret_after");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Parametrised writeback stage with an integrated register file, compare-flag register and retired-instruction counter. It sits after the MEM stage: it captures the MEM result each cycle, commits it to the architectural register file, and serves combinational read ports to decode. It extends the earlier fixed 32x32 writeback with configurable width, depth and read-port count, stall hold, a hardwired-zero register, bubble-qualified flag writes and retirement counting.

## Interface
Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, register count (power of two); RA = $clog2(NREGS)
- NRD, 2, number of combinational read ports
- CRW, 2, compare-flag register width
- R0_ZERO, 1, when 1 register 0 reads as 0 and ignores writes

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- stall  in  1  hold WB stage contents; suppress commits
- mem_bubble  in  1  MEM slot is empty
- mem_pc  in  XLEN  MEM instruction PC
- mem_res  in  XLEN  MEM result
- mem_rd  in  RA  destination register
- mem_w_rd  in  1  instruction writes rd
- mem_w_cr  in  1  instruction writes compare flags
- mem_cmp_res  in  CRW  compare flags
- wb_pc  out  XLEN  WB-stage PC
- wb_res  out  XLEN  WB-stage result
- wb_rd  out  RA  WB-stage destination
- wb_w_rd  out  1  WB write enable as committed: w_rd && !bubble && !stall && !(R0_ZERO && rd==0)
- wb_bubble  out  1  WB slot empty
- rd_addr  in  NRD x RA  read addresses
- rd_data  out  NRD x XLEN  read data
- cmp_reg  out  CRW  compare-flag register
- instret  out  64  retired-instruction count

## Operation
- Stage register (pc, res, rd, w_rd, bubble): on rst -> pc/res/rd = 0, w_rd = 0, bubble = 1. Otherwise, if !stall, load from MEM; if stall, hold.
- Register commit: at posedge, if wb_w_rd is high, regs[wb_rd] <= wb_res. A stalled WB slot does not write; it commits exactly once, on the cycle stall is low.
- cmp_reg: at posedge, if mem_w_cr && !mem_bubble && !stall, cmp_reg <= mem_cmp_res. Bubbles never alter the flags.
- instret: increments by 1 on each posedge where !wb_bubble && !stall. Wraps modulo 2^64.
- Read ports, all combinational and independent:
  - rd_data[i] = 0 when R0_ZERO && rd_addr[i]==0.
  - Otherwise the bypass value (see Configuration), else regs[rd_addr[i]].
- Reset:
  - Clears all NREGS registers, cmp_reg and instret to 0; the stage register resets as above.
  - Reset wins over stall. Any in-flight slot is discarded without commit or count.
- All outputs are registered except rd_data and wb_w_rd.

## Timing
- MEM -> WB capture latency: 1 cycle. A WB-stage result is visible in regs one cycle after entering WB, unless stalled.
- cmp_reg is updated 1 cycle after MEM presents the flags, i.e. in parallel with WB capture.
- Simultaneous commit and read of the same register: without bypass, old value; with bypass, new value.
- Stall asserted N cycles: WB outputs are constant and there are no regs, cmp_reg or instret changes; commit occurs on the first cycle stall drops.
- Back-to-back writes to the same rd: the later one wins, in order.
- First cycle after rst deasserts: wb_bubble = 1 and instret = 0.

## Configuration
- WB_BYPASS_EN defined: when wb_w_rd && rd_addr[i]==wb_rd, rd_data[i] = wb_res (same-cycle write-through). This removes the one-cycle RAW hazard for decode.
- WB_BYPASS_EN undefined: rd_data always reads the stored array. Decode must interlock one extra cycle.

## Test plan
- Reset: apply rst for 2 cycles with mem_bubble=0 and mem_w_rd=1 -> after release, all reads return 0, cmp_reg=0, instret=0, wb_bubble=1.
- Basic commit: MEM presents rd=5, res=0xDEADBEEF, w_rd=1 -> WB next cycle; rd_data(addr 5)=0xDEADBEEF from the cycle after that, and instret=1.
- R0 write (R0_ZERO=1): rd=0, res=0x1234, w_rd=1 -> wb_w_rd=0; reading addr 0 returns 0; instret still increments.
- Stall hold: WB holds rd=3, res=7 while stall is high for 3 cycles -> regs[3] unchanged and instret unchanged; on release, regs[3]=7 and instret +1 exactly once.
- Flags: mem_w_cr=1 with mem_cmp_res=2'b10 and mem_bubble=1 -> cmp_reg unchanged; the same with mem_bubble=0 -> cmp_reg=2'b10 next cycle.
- Bypass: WB commits rd=9 value 0xA5 while rd_addr[1]=9 in the same cycle -> rd_data[1]=0xA5 with WB_BYPASS_EN, the old value without it.
